grf_dump_reader: RTL and testbench
==================================

Name: grf_dump_reader

Overview:
- Debug/trace reader for the 32x32 general register file. It drives one GRF read port and sequentially reads a masked subset of registers.
- Each read value is streamed out over a valid/ready handshake, together with its register index and a last flag.
- It keeps a running XOR checksum of all transferred words.
- It sits beside the CPU datapath on a spare GRF read port and feeds the testbench/trace logger or a debug UART.

Parameters:
- NREG, 32, number of registers scanned (indices 0..NREG-1).
- AW, 5, register index width (log2 NREG).
- DW, 32, register data width.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a dump; sampled only in IDLE.
- mask  input  NREG  bit i set = dump register i; latched on accepted start.
- busy  output  1  high in SCAN and HOLD.
- done  output  1  one-cycle pulse when a dump completes.
- rf_ra  output  AW  GRF read address.
- rf_rd  input  DW  GRF read data (combinational from rf_ra; register 0 reads 0).
- out_valid  output  1  out_* hold a word.
- out_ready  input  1  consumer accepts the word when high with out_valid.
- out_idx  output  AW  index of the word on out_data.
- out_data  output  DW  register value snapshot.
- out_last  output  1  word is the highest-index set bit of the latched mask.
- checksum  output  DW  XOR of all accepted words of the current/last dump.

Behaviour:
- Reset: state=IDLE; busy, done, out_valid, out_last = 0; rf_ra, out_idx, out_data, checksum = 0; latched mask and idx = 0. Reset mid-dump aborts immediately and emits no done.
- FSM states: IDLE, SCAN, HOLD, DONE.
- IDLE:
  - rf_ra=0.
  - start=1 with mask!=0: latch mask, set idx=0, clear checksum, go to SCAN.
  - start=1 with mask==0: clear checksum, go to DONE.
  - start=0: stay.
- SCAN (one index examined per cycle):
  - rf_ra=idx.
  - mask_l[idx]=1: register out_data<=rf_rd, out_idx<=idx, out_last<=(mask_l bits above idx all 0), out_valid<=1, go to HOLD.
  - mask_l[idx]=0: idx<=idx+1, stay in SCAN. This path cannot run past NREG-1, because the highest set bit always causes HOLD first.
- HOLD:
  - out_valid=1; out_idx, out_data and out_last stay stable until accepted.
  - On out_valid&&out_ready: checksum<=checksum^out_data, out_valid<=0.
  - After acceptance: if out_last, go to DONE; else idx<=idx+1 and go to SCAN.
  - No acceptance: stay in HOLD indefinitely; there is no timeout.
- DONE:
  - done=1 for exactly this cycle; busy=0; go to IDLE next cycle.
  - start in DONE is ignored.
- start while busy is ignored; mask changes after acceptance have no effect.
- Snapshot semantics: out_data is the GRF value at the posedge ending that index's SCAN cycle. GRF writes in the same cycle are not visible; writes to the held register during HOLD do not change out_data.
- Throughput: 2 cycles per selected register with out_ready held high, plus 1 cycle per skipped index.
- Checksum holds its value after DONE until the next accepted start.
- Index arithmetic is AW bits; idx never wraps (see SCAN).

Test Plan:
- Preload grf[i]=0x100+i, mask=0x0000000E, out_ready=1, start pulsed in cycle 0:
  - beats are (1,0x101), (2,0x102), (3,0x103,last);
  - done pulses once;
  - checksum=0x00000100.
- mask=0xFFFFFFFF, out_ready=1, grf[i]=i:
  - 32 beats, idx 0..31, first beat data 0;
  - out_last only on idx 31;
  - done in cycle 65 after start;
  - checksum=0x00000000.
- mask=0x80000001, out_ready held low for 5 cycles on each beat:
  - out_* stay stable throughout the stall;
  - exactly 2 beats (0,0) then (31,grf[31]); the second beat has out_last=1.
- mask=0 with start: no out_valid; done in the next cycle; checksum=0; busy stays 0.
- start pulsed during HOLD with a different mask: ignored, and the original sequence completes unchanged.
- Assert reset while in HOLD: next cycle out_valid=0, busy=0, rf_ra=0, checksum=0, no done pulse; a following start gives a correct full dump.

Source files
------------

// File: rtl/grf_dump_reader.sv
// Debug/trace reader: scans a masked subset of the general register file through one
// read port and streams each value out over valid/ready, keeping an XOR checksum.
module grf_dump_reader #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [NREG-1:0] i_mask,
  output logic            o_busy,
  output logic            o_done,
  output logic [AW-1:0]   o_rf_ra,
  input  logic [DW-1:0]   i_rf_rd,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [AW-1:0]   o_out_idx,
  output logic [DW-1:0]   o_out_data,
  output logic            o_out_last,
  output logic [DW-1:0]   o_checksum
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD, S_DONE} state_t;

  state_t          r_state;
  logic [NREG-1:0] r_mask;
  logic [AW-1:0]   r_idx;
  logic            r_out_valid;
  logic [AW-1:0]   r_out_idx;
  logic [DW-1:0]   r_out_data;
  logic            r_out_last;
  logic [DW-1:0]   r_checksum;

  logic [NREG-1:0] w_upper;
  logic            w_sel;
  logic            w_last;

  // Bits of the latched mask strictly above the current index; none set means last beat.
  assign w_upper = (r_mask >> r_idx) >> 1;
  assign w_last  = (w_upper == '0);
  assign w_sel   = r_mask[r_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_checksum  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_checksum <= '0;
            if (i_mask != '0) begin
              r_mask  <= i_mask;
              r_idx   <= '0;
              r_state <= S_SCAN;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_SCAN: begin
          if (w_sel) begin
            r_out_data  <= i_rf_rd;
            r_out_idx   <= r_idx;
            r_out_last  <= w_last;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_idx <= r_idx + AW'(1);
          end
        end
        S_HOLD: begin
          if (i_out_ready) begin
            r_checksum  <= r_checksum ^ r_out_data;
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + AW'(1);
              r_state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state == S_SCAN) || (r_state == S_HOLD);
  assign o_done      = (r_state == S_DONE);
  assign o_rf_ra     = (r_state == S_SCAN) ? r_idx : '0;
  assign o_out_valid = r_out_valid;
  assign o_out_idx   = r_out_idx;
  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;
  assign o_checksum  = r_checksum;

endmodule

// File: tb/tb_grf_dump_reader.sv
// Directed bench for grf_dump_reader: expected beats are queued at stimulus time and
// popped by a monitor whenever a beat is accepted.
module tb_grf_dump_reader;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [NREG-1:0] mask;
  logic            busy, done;
  logic [AW-1:0]   rf_ra;
  logic [DW-1:0]   rf_rd;
  logic            out_valid, out_ready, out_last;
  logic [AW-1:0]   out_idx;
  logic [DW-1:0]   out_data, checksum;

  logic [DW-1:0] grf [NREG];

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int beat_cnt = 0;

  always #5 clk = ~clk;

  assign rf_rd = (rf_ra == '0) ? '0 : grf[rf_ra];

  grf_dump_reader #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .i_start(start), .i_mask(mask),
    .o_busy(busy), .o_done(done), .o_rf_ra(rf_ra), .i_rf_rd(rf_rd),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_idx(out_idx),
    .o_out_data(out_data), .o_out_last(out_last), .o_checksum(checksum)
  );

  // Monitor: stall stability and scoreboard compare on every accepted beat.
  beat_t mon_prev;
  logic  mon_hold = 1'b0;
  always @(negedge clk) begin
    beat_t cur, e;
    cur = {out_idx, out_data, out_last};
    if (reset) begin
      mon_hold = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (mon_hold) begin
        checks++;
        assert ({out_valid, cur} === {1'b1, mon_prev}) else begin
          errors++;
          $error("FAIL stall_stable observed=%h required=%h", {out_valid, cur}, {1'b1, mon_prev});
        end
      end
      if (out_valid && out_ready) begin
        beat_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $error("FAIL unexpected_beat observed idx=%0d data=%h required=no beat", out_idx, out_data);
        end else begin
          e = exp_q.pop_front();
          assert (cur === e) else begin
            errors++;
            $error("FAIL beat observed idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                   cur.idx, cur.data, cur.last, e.idx, e.data, e.last);
          end
        end
      end
      mon_hold = out_valid && !out_ready;
      mon_prev = cur;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h required=%h", tag, obs, req);
    end
  endtask

  function automatic int hi_bit(input logic [NREG-1:0] m);
    int h = -1;
    for (int i = 0; i < NREG; i++) if (m[i]) h = i;
    return h;
  endfunction

  // Queue the beats a mask should produce from the current GRF contents; return their XOR.
  task automatic push_exp(input logic [NREG-1:0] m, output logic [DW-1:0] cks);
    beat_t b;
    int h = hi_bit(m);
    cks = '0;
    for (int i = 0; i < NREG; i++) begin
      if (m[i]) begin
        b.idx  = AW'(i);
        b.data = (i == 0) ? '0 : grf[i];
        b.last = (i == h);
        exp_q.push_back(b);
        cks ^= b.data;
      end
    end
  endtask

  task automatic pulse_start(input logic [NREG-1:0] m);
    @(posedge clk); #1;
    start = 1'b1;
    mask  = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int maxc);
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    check("valid_timeout", 64'd0, 64'd1);
  endtask

  // Returns the cycle (counted from the start cycle) in which done was seen.
  task automatic wait_done(input int maxc, output int n);
    n = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (done) begin
        n = k;
        check("busy_in_done", 64'(busy), 64'd0);
        return;
      end
    end
    check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic finish_dump(input logic [DW-1:0] cks, input int dc0);
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_valid", 64'(out_valid), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("checksum", 64'(checksum), 64'(cks));
    check("done_pulses", 64'(done_cnt - dc0), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] cks;
    int n, dc, bc;
    reset = 1'b1; start = 1'b0; mask = '0; out_ready = 1'b1;
    for (int i = 0; i < NREG; i++) grf[i] = 32'h100 + i;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {busy, done, out_valid, out_last, rf_ra, out_idx},
          {4'b0000, 5'd0, 5'd0});
    check("rst_data", {out_data, checksum}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Three selected registers, consumer always ready.
    push_exp(32'h0000_000E, cks);
    dc = done_cnt;
    pulse_start(32'h0000_000E);
    wait_done(100, n);
    check("t1_done_cycle", 64'(n), 64'd8);
    check("t1_cks_const", 64'(cks), 64'h100);
    finish_dump(cks, dc);

    // Full mask.
    for (int i = 0; i < NREG; i++) grf[i] = i;
    push_exp(32'hFFFF_FFFF, cks);
    dc = done_cnt; bc = beat_cnt;
    pulse_start(32'hFFFF_FFFF);
    wait_done(200, n);
    check("t2_done_cycle", 64'(n), 64'd65);
    check("t2_beats", 64'(beat_cnt - bc), 64'd32);
    finish_dump(32'h0, dc);

    // End bits with 5-cycle stalls; the held register is overwritten during its stall.
    for (int i = 0; i < NREG; i++) grf[i] = 32'h300 + i;
    out_ready = 1'b0;
    push_exp(32'h8000_0001, cks);
    dc = done_cnt; bc = beat_cnt;
    pulse_start(32'h8000_0001);
    for (int b = 0; b < 2; b++) begin
      wait_valid(64);
      if (b == 1) grf[31] = 32'hDEAD_BEEF;
      repeat (5) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
    wait_done(20, n);
    check("t3_beats", 64'(beat_cnt - bc), 64'd2);
    finish_dump(cks, dc);

    // Empty mask.
    out_ready = 1'b1;
    dc = done_cnt; bc = beat_cnt;
    pulse_start('0);
    wait_done(10, n);
    check("t4_done_cycle", 64'(n), 64'd1);
    finish_dump(32'h0, dc);
    check("t4_no_beats", 64'(beat_cnt - bc), 64'd0);

    // Start with another mask while holding is ignored.
    for (int i = 0; i < NREG; i++) grf[i] = 32'h400 + i;
    out_ready = 1'b0;
    push_exp(32'h0000_0003, cks);
    dc = done_cnt;
    pulse_start(32'h0000_0003);
    wait_valid(10);
    pulse_start(32'h0000_00F0);
    out_ready = 1'b1;
    wait_done(50, n);
    finish_dump(cks, dc);

    // Reset while holding the second beat.
    for (int i = 0; i < NREG; i++) grf[i] = 32'h200 + i;
    out_ready = 1'b0;
    push_exp(32'h0000_0006, cks);
    pulse_start(32'h0000_0006);
    wait_valid(10);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    wait_valid(10);
    check("t6_cks_before", 64'(checksum), 64'h201);
    dc = done_cnt;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t6_after_rst", {out_valid, busy, done, rf_ra}, {3'b000, 5'd0});
    check("t6_cks_cleared", 64'(checksum), 64'd0);
    repeat (3) @(negedge clk);
    check("t6_no_done", 64'(done_cnt - dc), 64'd0);
    exp_q.delete();

    // Full dump after the abort.
    out_ready = 1'b1;
    for (int i = 0; i < NREG; i++) grf[i] = 32'h0101_0000 * i + 32'h3 * i + 32'h7;
    push_exp(32'hFFFF_FFFF, cks);
    dc = done_cnt;
    pulse_start(32'hFFFF_FFFF);
    wait_done(200, n);
    check("t7_done_cycle", 64'(n), 64'd65);
    finish_dump(cks, dc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=timeout required=finish");
    $fatal(1, "timeout");
  end
endmodule
